// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 response packer: command codes, response
// codes, the controller state encoding and the default timeout.
package dht11_pkg;

    localparam logic [7:0] CMD_STATUS      = 8'h01;
    localparam logic [7:0] CMD_HUMIDITY    = 8'h02;
    localparam logic [7:0] CMD_TEMPERATURE = 8'h03;

    localparam logic [7:0] RSP_STATUS       = 8'h08;
    localparam logic [7:0] RSP_HUMIDITY     = 8'h09;
    localparam logic [7:0] RSP_TEMPERATURE  = 8'h0A;
    localparam logic [7:0] RSP_SENSOR_ERROR = 8'h1F;
    localparam logic [7:0] RSP_CHECKSUM_ERR = 8'h2F;
    localparam logic [7:0] RSP_INVALID      = 8'hEF;

    // 100 ms at 50 MHz
    localparam int DEFAULT_TIMEOUT_CYCLES = 5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_LATCH,
        ST_SEND0,
        ST_SEND1,
        ST_SEND2
    } state_t;

    function automatic logic is_valid_cmd(input logic [7:0] code);
        return (code == CMD_STATUS) || (code == CMD_HUMIDITY) || (code == CMD_TEMPERATURE);
    endfunction

endpackage

// File: rtl/dht11_response_packer_cycle_timer.sv
// Up-counter with clear/enable that flags when it reaches TERMINAL_COUNT-1.
// The count saturates there so expired stays high until cleared.
module cycle_timer #(
    parameter int TERMINAL_COUNT = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TERMINAL_COUNT > 1) ? $clog2(TERMINAL_COUNT) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TERMINAL_COUNT - 1));

    // count enabled cycles since the last clear, holding at the terminal value
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_response_packer.sv
// DHT11 response packer: takes a command byte, runs one sensor measurement,
// and streams a three-byte response {code, int, frac} to the UART.
// Optional feature macro: DHT11_CHECKSUM_CHECK_EN (report checksum errors
// as 0x2F; when undefined checksum_error is ignored).
module dht11_response_packer
    import dht11_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       command_valid,
    input  logic [7:0] command_code,
    output logic       command_ready,
    output logic       sensor_enable,
    output logic       sensor_start,
    input  logic       data_ready,
    input  logic       sensor_error,
    input  logic       checksum_error,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [7:0] code_q;
    logic       invalid_q;
    logic       timeout_q;
    logic       dr_q;
    logic [7:0] byte0_q, byte1_q, byte2_q;
    logic       timer_clear, timer_enable, timer_expired;
    logic       dr_rise;

    assign dr_rise = data_ready && !dr_q;

`ifndef DHT11_CHECKSUM_CHECK_EN
    logic unused_checksum;
    assign unused_checksum = checksum_error;
`endif

    cycle_timer #(
        .TERMINAL_COUNT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // next state and state-decoded outputs; tx_ready/command_valid only steer state_d
    always_comb begin
        state_d       = state_q;
        command_ready = 1'b0;
        sensor_enable = 1'b0;
        sensor_start  = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;
        busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                command_ready = 1'b1;
                if (command_valid)
                    state_d = is_valid_cmd(command_code) ? ST_START : ST_LATCH;
            end
            ST_START: begin
                sensor_enable = 1'b1;
                sensor_start  = 1'b1;
                timer_clear   = 1'b1;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                sensor_enable = 1'b1;
                timer_enable  = 1'b1;
                if (dr_rise || timer_expired) state_d = ST_LATCH;
            end
            ST_LATCH: state_d = ST_SEND0;
            ST_SEND0: begin
                tx_valid = 1'b1;
                tx_data  = byte0_q;
                if (tx_ready) state_d = ST_SEND1;
            end
            ST_SEND1: begin
                tx_valid = 1'b1;
                tx_data  = byte1_q;
                if (tx_ready) state_d = ST_SEND2;
            end
            ST_SEND2: begin
                tx_valid = 1'b1;
                tx_data  = byte2_q;
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // command capture, timeout flag, data_ready edge register and frame latch
    always_ff @(posedge clock) begin
        if (reset) begin
            code_q    <= 8'h00;
            invalid_q <= 1'b0;
            timeout_q <= 1'b0;
            dr_q      <= 1'b0;
            byte0_q   <= 8'h00;
            byte1_q   <= 8'h00;
            byte2_q   <= 8'h00;
        end else begin
            // tracked every cycle so a level already high when WAIT starts is not an edge
            dr_q <= data_ready;
            case (state_q)
                ST_IDLE: begin
                    if (command_valid) begin
                        code_q    <= command_code;
                        invalid_q <= !is_valid_cmd(command_code);
                        timeout_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // an edge on the terminal cycle still counts as data
                    if (!dr_rise && timer_expired) timeout_q <= 1'b1;
                end
                ST_LATCH: begin
                    byte1_q <= 8'h00;
                    byte2_q <= 8'h00;
                    if (invalid_q) begin
                        byte0_q <= RSP_INVALID;
                    end else if (timeout_q || sensor_error) begin
                        byte0_q <= RSP_SENSOR_ERROR;
`ifdef DHT11_CHECKSUM_CHECK_EN
                    end else if (checksum_error) begin
                        byte0_q <= RSP_CHECKSUM_ERR;
`endif
                    end else if (code_q == CMD_STATUS) begin
                        byte0_q <= RSP_STATUS;
                    end else if (code_q == CMD_HUMIDITY) begin
                        byte0_q <= RSP_HUMIDITY;
                        byte1_q <= hum_int;
                        byte2_q <= hum_float;
                    end else begin
                        byte0_q <= RSP_TEMPERATURE;
                        byte1_q <= temp_int;
                        byte2_q <= temp_float;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_response_packer.sv
// Directed bench for dht11_response_packer with a small sensor model and a
// UART sink; the DUT runs with a 100-cycle timeout.
module tb_dht11_response_packer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       command_valid = 1'b0;
    logic [7:0] command_code = 8'h00;
    logic       command_ready;
    logic       sensor_enable;
    logic       sensor_start;
    logic       data_ready = 1'b0;
    logic       sensor_error = 1'b0;
    logic       checksum_error = 1'b0;
    logic [7:0] hum_int = 8'h00, hum_float = 8'h00, temp_int = 8'h00, temp_float = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dht11_response_packer #(.TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset),
        .command_valid(command_valid), .command_code(command_code), .command_ready(command_ready),
        .sensor_enable(sensor_enable), .sensor_start(sensor_start),
        .data_ready(data_ready), .sensor_error(sensor_error), .checksum_error(checksum_error),
        .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int), .temp_float(temp_float),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one command and run sensor model + UART sink until three bytes
    // are received or the cycle budget runs out. Cycle 0 is the cycle after
    // acceptance. dr_delay < 0 means data_ready never rises.
    task automatic run_frame(input logic [7:0] code, input int dr_delay, input bit toggle,
                             output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                             output int nbytes, output int starts, output int start_cyc,
                             output int first_valid, output int unstable);
        logic [7:0] rx [3];
        logic       pv, pr;
        logic [7:0] pd;
        rx[0] = 8'hxx; rx[1] = 8'hxx; rx[2] = 8'hxx;
        nbytes = 0; starts = 0; start_cyc = -1; first_valid = -1; unstable = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        command_valid = 1'b1;
        command_code  = code;
        tick;
        command_valid = 1'b0;
        for (int c = 0; c < 400 && nbytes < 3; c++) begin
            if (sensor_start) begin
                starts++;
                if (start_cyc < 0) start_cyc = c;
            end
            data_ready = (start_cyc >= 0 && dr_delay >= 0 && (c - start_cyc) >= dr_delay);
            tx_ready = toggle ? c[0] : 1'b1;
            if (tx_valid && first_valid < 0) first_valid = c;
            if (tx_valid && pv && !pr && tx_data !== pd) unstable++;
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            if (tx_valid && tx_ready) begin
                rx[nbytes] = tx_data;
                nbytes++;
            end
            tick;
        end
        data_ready = 1'b0;
        tx_ready   = 1'b1;
        b0 = rx[0]; b1 = rx[1]; b2 = rx[2];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL reset_command_ready got=%b exp=1", command_ready); end
        checks++; if (sensor_enable !== 1'b0) begin errors++; $display("FAIL reset_sensor_enable got=%b exp=0", sensor_enable); end
        checks++; if (sensor_start !== 1'b0) begin errors++; $display("FAIL reset_sensor_start got=%b exp=0", sensor_start); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_humidity;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        hum_int = 8'h3C; hum_float = 8'h00;
        run_frame(8'h02, 40, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checks++; if (n !== 3) begin errors++; $display("FAIL hum_count got=%0d exp=3", n); end
        checks++; if ({b0, b1, b2} !== 24'h093C00) begin errors++; $display("FAIL hum_bytes got=%h exp=093c00", {b0, b1, b2}); end
        checks++; if (st !== 1) begin errors++; $display("FAIL hum_start_pulses got=%0d exp=1", st); end
        checks++; if (sc !== 0) begin errors++; $display("FAIL hum_start_cycle got=%0d exp=0", sc); end
        checks++; if (fv - sc !== 42) begin errors++; $display("FAIL hum_valid_latency got=%0d exp=42", fv - sc); end
        checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL hum_ready_after got=%b exp=1", command_ready); end
    endtask

    task automatic test_temperature_toggle;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        temp_int = 8'h19; temp_float = 8'h05;
        run_frame(8'h03, 7, 1'b1, b0, b1, b2, n, st, sc, fv, us);
        checks++; if ({b0, b1, b2} !== 24'h0A1905) begin errors++; $display("FAIL temp_bytes got=%h exp=0a1905", {b0, b1, b2}); end
        checks++; if (us !== 0) begin errors++; $display("FAIL temp_stable got=%0d changes exp=0", us); end
    endtask

    task automatic test_timeout;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        run_frame(8'h01, -1, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checks++; if ({b0, b1, b2} !== 24'h1F0000) begin errors++; $display("FAIL timeout_bytes got=%h exp=1f0000", {b0, b1, b2}); end
        checks++; if (fv - sc !== 102) begin errors++; $display("FAIL timeout_latency got=%0d exp=102", fv - sc); end
    endtask

    task automatic test_already_high;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        temp_int = 8'h22; temp_float = 8'h01;
        run_frame(8'h03, 0, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checks++; if ({b0, b1, b2} !== 24'h1F0000) begin errors++; $display("FAIL level_ignored_bytes got=%h exp=1f0000", {b0, b1, b2}); end
        checks++; if (fv - sc !== 102) begin errors++; $display("FAIL level_ignored_latency got=%0d exp=102", fv - sc); end
    endtask

    task automatic test_sensor_error;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        hum_int = 8'h41; hum_float = 8'h02;
        sensor_error = 1'b1;
        run_frame(8'h02, 5, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        sensor_error = 1'b0;
        checks++; if ({b0, b1, b2} !== 24'h1F0000) begin errors++; $display("FAIL sensor_error_bytes got=%h exp=1f0000", {b0, b1, b2}); end
    endtask

    task automatic test_checksum;
        logic [7:0] b0, b1, b2;
        logic [23:0] exp;
        int n, st, sc, fv, us;
        hum_int = 8'h3C; hum_float = 8'h07;
        checksum_error = 1'b1;
        run_frame(8'h02, 3, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checksum_error = 1'b0;
`ifdef DHT11_CHECKSUM_CHECK_EN
        exp = 24'h2F0000;
`else
        exp = 24'h093C07;
`endif
        checks++; if ({b0, b1, b2} !== exp) begin errors++; $display("FAIL checksum_bytes got=%h exp=%h", {b0, b1, b2}, exp); end
    endtask

    task automatic test_invalid;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        run_frame(8'h7E, 2, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checks++; if ({b0, b1, b2} !== 24'hEF0000) begin errors++; $display("FAIL invalid_bytes got=%h exp=ef0000", {b0, b1, b2}); end
        checks++; if (st !== 0) begin errors++; $display("FAIL invalid_start_pulses got=%0d exp=0", st); end
        checks++; if (fv !== 1) begin errors++; $display("FAIL invalid_latency got=%0d exp=1", fv); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b0, b1, b2;
        int n, st, sc, fv, us;
        hum_int = 8'h55; hum_float = 8'h66;
        tx_ready = 1'b1;
        command_valid = 1'b1; command_code = 8'h02;
        tick;                       // START
        command_valid = 1'b0;
        tick;                       // WAIT
        data_ready = 1'b1;
        tick;                       // LATCH
        tick;                       // SEND0, accepted at next edge
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h09) begin errors++; $display("FAIL abort_send0 got=%b/%h exp=1/09", tx_valid, tx_data); end
        tick;                       // SEND1, hold it there
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL abort_send1 got=%b/%h exp=1/55", tx_valid, tx_data); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        data_ready = 1'b0;
        tx_ready = 1'b1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL abort_command_ready got=%b exp=1", command_ready); end
        checks++; if (sensor_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b/%b exp=0/0", sensor_enable, busy); end
        tick;
        run_frame(8'h01, 3, 1'b0, b0, b1, b2, n, st, sc, fv, us);
        checks++; if ({b0, b1, b2} !== 24'h080000) begin errors++; $display("FAIL after_abort_bytes got=%h exp=080000", {b0, b1, b2}); end
        checks++; if (n !== 3) begin errors++; $display("FAIL after_abort_count got=%0d exp=3", n); end
    endtask

    initial begin
        test_reset;
        test_humidity;
        test_temperature_toggle;
        test_timeout;
        test_already_high;
        test_sensor_error;
        test_checksum;
        test_invalid;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
